// File: rtl/pong_pkg.sv
// Shared types, screen/ball constants and small helpers for the pong game controller.
package pong_pkg;

    localparam int POS_W   = 10;
    localparam int SCORE_W = 4;

    localparam int SCREEN_WIDTH_DEF  = 640;
    localparam int SCREEN_HEIGHT_DEF = 480;
    localparam int BALL_SIZE_DEF     = 7;
    localparam int BALL_SPEED_DEF    = 3;
    localparam int BORDER_OFFSET_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // Score increment that sticks at the limit instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s,
                                                     input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? lim : s + 1'b1;
    endfunction

endpackage

// File: rtl/pong_ball_step.sv
// One-axis ball step: proposes the next position and flags when the move would cross a limit.
module pong_ball_step
    import pong_pkg::*;
#(
    parameter int SPEED    = BALL_SPEED_DEF,
    parameter int LO_LIMIT = BORDER_OFFSET_DEF + BALL_SPEED_DEF,
    parameter int HI_LIMIT = SCREEN_WIDTH_DEF - BALL_SIZE_DEF
) (
    input  logic [POS_W-1:0] pos,
    input  logic             inc,
    output logic [POS_W-1:0] next_pos,
    output logic             at_edge
);

    localparam int EW = POS_W + 1;
    localparam logic [EW-1:0] SPEED_E = EW'(SPEED);
    localparam logic [EW-1:0] LO_E    = EW'(LO_LIMIT);
    localparam logic [EW-1:0] HI_E    = EW'(HI_LIMIT);

    logic [EW-1:0] pos_e;
    logic [EW-1:0] sum_e;

    // One extra bit keeps the upward compare free of 10-bit wrap.
    always_comb begin
        pos_e    = {1'b0, pos};
        sum_e    = pos_e + SPEED_E;
        at_edge  = inc ? (sum_e > HI_E) : (pos_e < LO_E);
        next_pos = pos;
        if (!at_edge) begin
            next_pos = inc ? sum_e[POS_W-1:0] : pos - SPEED_E[POS_W-1:0];
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/score FSM and frame-rate ball motion with wall bounce and miss detection.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int BALL_SIZE     = BALL_SIZE_DEF,
    parameter int BALL_SPEED    = BALL_SPEED_DEF,
    parameter int BORDER_OFFSET = BORDER_OFFSET_DEF,
    parameter int SERVE_FRAMES  = 60,
    parameter int WIN_SCORE     = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame,
    input  logic               start,
    input  logic               hit_left,
    input  logic               hit_right,
    output logic [POS_W-1:0]   ball_x,
    output logic [POS_W-1:0]   ball_y,
    output logic               ball_dx,
    output logic               ball_dy,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [2:0]         game_state,
    output logic               winner_left
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [POS_W-1:0]   CENTER_X  = POS_W'(SCREEN_WIDTH / 2);
    localparam logic [POS_W-1:0]   CENTER_Y  = POS_W'(SCREEN_HEIGHT / 2);
    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_END = CNT_W'(SERVE_FRAMES - 1);

    state_t             state, state_nx;
    logic [POS_W-1:0]   x_nx, y_nx, x_step, y_step;
    logic               dx_nx, dy_nx, x_edge, y_edge, y_inc;
    logic [SCORE_W-1:0] sl_nx, sr_nx, new_score;
    logic               win_nx, point_left, point_left_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    // dy=1 means moving up, i.e. toward smaller row numbers.
    assign y_inc = ~ball_dy;

    pong_ball_step #(
        .SPEED   (BALL_SPEED),
        .LO_LIMIT(BORDER_OFFSET + BALL_SPEED),
        .HI_LIMIT(SCREEN_WIDTH - BALL_SIZE)
    ) u_step_x (
        .pos     (ball_x),
        .inc     (ball_dx),
        .next_pos(x_step),
        .at_edge (x_edge)
    );

    pong_ball_step #(
        .SPEED   (BALL_SPEED),
        .LO_LIMIT(BORDER_OFFSET + BALL_SPEED),
        .HI_LIMIT(SCREEN_HEIGHT - BALL_SIZE - BORDER_OFFSET)
    ) u_step_y (
        .pos     (ball_y),
        .inc     (y_inc),
        .next_pos(y_step),
        .at_edge (y_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ball_x      <= CENTER_X;
            ball_y      <= CENTER_Y;
            ball_dx     <= 1'b1;
            ball_dy     <= 1'b1;
            score_left  <= '0;
            score_right <= '0;
            winner_left <= 1'b0;
            cnt         <= '0;
            point_left  <= 1'b0;
        end else begin
            state       <= state_nx;
            ball_x      <= x_nx;
            ball_y      <= y_nx;
            ball_dx     <= dx_nx;
            ball_dy     <= dy_nx;
            score_left  <= sl_nx;
            score_right <= sr_nx;
            winner_left <= win_nx;
            cnt         <= cnt_nx;
            point_left  <= point_left_nx;
        end
    end

    assign game_state = state;

    always_comb begin
        state_nx      = state;
        x_nx          = ball_x;
        y_nx          = ball_y;
        dx_nx         = ball_dx;
        dy_nx         = ball_dy;
        sl_nx         = score_left;
        sr_nx         = score_right;
        win_nx        = winner_left;
        cnt_nx        = cnt;
        point_left_nx = point_left;
        new_score     = point_left ? score_inc(score_left, WIN_S)
                                   : score_inc(score_right, WIN_S);

        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    state_nx = ST_SERVE;
                    sl_nx    = '0;
                    sr_nx    = '0;
                    win_nx   = 1'b0;
                    cnt_nx   = '0;
                    x_nx     = CENTER_X;
                    y_nx     = CENTER_Y;
                end
            end
            ST_SERVE: begin
                x_nx = CENTER_X;
                y_nx = CENTER_Y;
                if (frame) begin
                    if (cnt == SERVE_END) begin
                        state_nx = ST_PLAY;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // Motion reads the registered dx, so a same-cycle hit only affects later frames.
                if (frame) begin
                    if (x_edge) begin
                        state_nx      = ST_POINT;
                        point_left_nx = ball_dx;
                    end else begin
                        x_nx = x_step;
                        y_nx = y_step;
                        if (y_edge) dy_nx = ~ball_dy;
                    end
                end
                if (hit_left && !hit_right)      dx_nx = 1'b1;
                else if (hit_right && !hit_left) dx_nx = 1'b0;
            end
            ST_POINT: begin
                if (point_left) sl_nx = new_score;
                else            sr_nx = new_score;
                if (new_score == WIN_S) begin
                    state_nx = ST_GAME_OVER;
                    win_nx   = point_left;
                end else begin
                    state_nx = ST_SERVE;
                    x_nx     = CENTER_X;
                    y_nx     = CENTER_Y;
                    dx_nx    = point_left;
                    dy_nx    = 1'b1;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with hand-computed expectations at default parameters.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame, start, hit_left, hit_right;
    logic [9:0] ball_x, ball_y;
    logic       ball_dx, ball_dy, winner_left;
    logic [3:0] score_left, score_right;
    logic [2:0] game_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame      (frame),
        .start      (start),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_dx    (ball_dx),
        .ball_dy    (ball_dy),
        .score_left (score_left),
        .score_right(score_right),
        .game_state (game_state),
        .winner_left(winner_left)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, game_state, 0);
        check({tag, "_x"}, ball_x, 320);
        check({tag, "_y"}, ball_y, 240);
        check({tag, "_dx"}, ball_dx, 1);
        check({tag, "_dy"}, ball_dy, 1);
        check({tag, "_sl"}, score_left, 0);
        check({tag, "_sr"}, score_right, 0);
        check({tag, "_win"}, winner_left, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; frame = 1'b0; start = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_reset_vals("rst");

        // Frames and hits are ignored in IDLE.
        hit_right = 1'b1;
        pulse_frame();
        hit_right = 1'b0;
        check("idle_frame_state", game_state, 0);
        check("idle_hit_dx", ball_dx, 1);

        start = 1'b1; tick(); start = 1'b0;
        check("start_state", game_state, 1);

        hit_right = 1'b1; tick(); hit_right = 1'b0;
        check("serve_hit_dx", ball_dx, 1);
        start = 1'b1; tick(); start = 1'b0;
        check("serve_start_state", game_state, 1);

        for (int i = 1; i <= 59; i++) pulse_frame();
        check("serve59_state", game_state, 1);
        check("serve59_x", ball_x, 320);
        check("serve59_y", ball_y, 240);
        pulse_frame();
        check("serve60_state", game_state, 2);
        check("serve60_x", ball_x, 320);

        hit_right = 1'b1; tick(); hit_right = 1'b0;
        check("play_hitr_dx", ball_dx, 0);
        hit_left = 1'b1; hit_right = 1'b1; tick(); hit_left = 1'b0; hit_right = 1'b0;
        check("play_both_dx", ball_dx, 0);

        // Leftward run: x reaches 5 after 105 frames, frame 106 misses.
        for (int k = 1; k <= 105; k++) begin
            pulse_frame();
            if (k == 1) begin
                check("f1_x", ball_x, 317);
                check("f1_y", ball_y, 237);
            end
            if (k == 78) begin
                check("f78_y", ball_y, 6);
                check("f78_dy", ball_dy, 1);
            end
            if (k == 79) begin
                check("bounce_y", ball_y, 6);
                check("bounce_dy", ball_dy, 0);
            end
            if (k == 80) check("f80_y", ball_y, 9);
        end
        check("f105_x", ball_x, 5);
        check("f105_y", ball_y, 84);
        check("f105_state", game_state, 2);
        pulse_frame();
        check("ptr_state", game_state, 3);
        check("ptr_x", ball_x, 5);
        check("ptr_sr", score_right, 0);
        tick();
        check("ptr_after_state", game_state, 1);
        check("ptr_after_sr", score_right, 1);
        check("ptr_after_x", ball_x, 320);
        check("ptr_after_y", ball_y, 240);
        check("ptr_after_dx", ball_dx, 0);
        check("ptr_after_dy", ball_dy, 1);

        // Nine left-scoring rounds: each takes 105 frames (x 320 -> 632, then a miss).
        for (int r = 1; r <= 9; r++) begin
            for (int i = 0; i < 60; i++) pulse_frame();
            check("rnd_play", game_state, 2);
            hit_left = 1'b1; tick(); hit_left = 1'b0;
            check("rnd_dx", ball_dx, 1);
            n = 0;
            while (n < 200 && game_state != 3) begin
                pulse_frame();
                n++;
            end
            check("rnd_frames", n, 105);
            check("rnd_point", game_state, 3);
            tick();
            if (r < 9) begin
                check("rnd_sl", score_left, r);
                check("rnd_state", game_state, 1);
            end else begin
                check("go_state", game_state, 4);
                check("go_sl", score_left, 9);
                check("go_sr", score_right, 1);
                check("go_win", winner_left, 1);
                check("go_x", ball_x, 632);
                check("go_y", ball_y, 81);
            end
        end

        for (int i = 0; i < 3; i++) pulse_frame();
        check("go_frame_state", game_state, 4);
        check("go_frame_x", ball_x, 632);
        check("go_frame_sl", score_left, 9);
        check("go_frame_win", winner_left, 1);

        start = 1'b1; tick(); start = 1'b0;
        check("restart_state", game_state, 1);
        check("restart_sl", score_left, 0);
        check("restart_sr", score_right, 0);
        check("restart_x", ball_x, 320);

        for (int i = 0; i < 60; i++) pulse_frame();
        check("p2_state", game_state, 2);
        pulse_frame();
        check("p2_x", ball_x, 323);

        // Reset wins over a simultaneous frame and hit.
        reset = 1'b1; frame = 1'b1; hit_right = 1'b1;
        tick();
        reset = 1'b0; frame = 1'b0; hit_right = 1'b0;
        check_reset_vals("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, 640, visible pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, 480, visible lines.
REQ-003 SHALL have parameter BALL_SIZE, 7, ball edge length in pixels.
REQ-004 SHALL have parameter BALL_SPEED, 3, pixels moved per frame on each axis.
REQ-005 SHALL have parameter BORDER_OFFSET, 5, playfield margin in pixels.
REQ-006 SHALL have parameter SERVE_FRAMES, 60, frames the ball is held before each serve.
REQ-007 SHALL have parameter WIN_SCORE, 9, score that ends the game.
REQ-008 SHALL have one clock and a synchronous, active-high reset: clk  in  1  pixel clock (25 MHz); reset  in  1  synchronous active-high reset.
REQ-009 SHALL have ports: frame  in  1  one-cycle pulse at start of vertical blanking; start  in  1  one-cycle start/restart request; hit_left  in  1  ball overlaps left paddle; hit_right  in  1  ball overlaps right paddle.
REQ-010 SHALL have ports: ball_x  out  10  ball left column; ball_y  out  10  ball top row; ball_dx  out  1  1=moving right; ball_dy  out  1  1=moving up.
REQ-011 SHALL have ports: score_left  out  4  0..WIN_SCORE; score_right  out  4  0..WIN_SCORE; game_state  out  3  encoded FSM state; winner_left  out  1  valid in GAME_OVER, 1=left won.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE, PLAY, POINT, GAME_OVER.
REQ-013 In IDLE: ball held at (320,240); start -> SERVE with scores cleared and serve counter cleared.
REQ-014 In SERVE: ball held at center; serve counter increments on each frame; on the frame that makes it equal SERVE_FRAMES -> PLAY, counter cleared.
REQ-015 In PLAY on frame, x axis: dx=0 and ball_x < BORDER_OFFSET+BALL_SPEED -> POINT for right, no move; dx=1 and ball_x+BALL_SPEED > SCREEN_WIDTH-BALL_SIZE -> POINT for left, no move; otherwise ball_x += or -= BALL_SPEED.
REQ-016 In PLAY on frame, y axis: dy=1 and ball_y < BORDER_OFFSET+BALL_SPEED -> ball_y unchanged, dy<=0; dy=0 and ball_y+BALL_SPEED > SCREEN_HEIGHT-BALL_SIZE-BORDER_OFFSET -> ball_y unchanged, dy<=1; otherwise ball_y -= or += BALL_SPEED. No 10-bit wrap permitted.
REQ-017 In PLAY any cycle: hit_left -> dx<=1; hit_right -> dx<=0; both high -> dx unchanged. Hits outside PLAY are ignored.
REQ-018 Frame and hit in the same cycle: movement uses the pre-edge dx; the new dx is visible the next cycle.
REQ-019 POINT SHALL last exactly one cycle: increment the scorer's score; if the new score equals WIN_SCORE -> GAME_OVER with winner_left set; else -> SERVE.
REQ-020 Leaving POINT to SERVE: ball recentered, dx set toward the conceding player (left scored -> dx=1), dy=1.
REQ-021 In GAME_OVER: scores, winner_left and ball frozen; start -> SERVE with scores cleared.
REQ-022 start SHALL be ignored in SERVE, PLAY and POINT; frame SHALL be ignored in IDLE and GAME_OVER.
REQ-023 Scores SHALL never exceed WIN_SCORE and never wrap.
REQ-024 All outputs SHALL be registered; a change is visible one cycle after the triggering edge.

Reset
REQ-025 reset SHALL dominate all inputs in the same cycle, including mid-PLAY and mid-POINT.
REQ-026 Reset values: state IDLE, ball_x=320, ball_y=240, dx=1, dy=1, scores 0, winner_left 0, serve counter 0.

Structure
REQ-027 The state enum and the screen and ball constants SHALL live in shared package pong_pkg.
REQ-028 Per-axis next-position and bounce/miss logic SHALL be one combinational sub-module, pong_ball_step, instantiated once per axis.

Verification
REQ-029 Reset, then start, then 60 frames -> state PLAY exactly after frame 60; ball stays at (320,240) until then.
REQ-030 PLAY, dy=1, ball_y=7, frame -> ball_y stays 7, dy=0; next frame -> ball_y=10.
REQ-031 PLAY, dx=0, ball_x=7, frame -> POINT for one cycle, score_right +1, then SERVE with ball at (320,240) and dx=0.
REQ-032 score_left=8, left scores -> score_left=9, state GAME_OVER, winner_left=1; frames are then ignored; start -> SERVE with both scores 0.
REQ-033 hit_left and hit_right high together with dx=0 -> dx stays 0; hit_left alone during SERVE -> dx unchanged.
REQ-034 reset asserted in the same cycle as frame and hit_right during PLAY -> all reset values on the next cycle.
